rst_seq_sync: RTL and testbench
===============================

// Module: rst_seq_sync
// PURPOSE
//   Parametrised reset synchroniser and sequencer for a single clock domain.
//   Asserts reset asynchronously and releases it synchronously through a
//   NUM_STAGES flop chain. Holds reset for a minimum stretch, then releases
//   NUM_OUT reset outputs in staggered order.
//   Also accepts a synchronous software reset request that re-runs the sequence.
//   Sits between the board/PLL reset and the subsystem reset trees.
// PARAMETERS
//   NUM_STAGES  2  synchroniser depth (>=2)
//   MIN_HOLD    4  extra cycles all outputs stay in reset after chain release (>=1)
//   NUM_OUT     3  number of sequenced reset outputs (>=1)
//   STAGGER     2  cycles between release of output i and output i+1 (>=1)
//   SW_PULSE    8  cycles all outputs are held in reset on a sw request (>=1)
// PORTS
//   clk         in   1        single clock
//   rst         in   1        asynchronous, active-high reset
//   sw_rst_req  in   1        synchronous to clk; 1-cycle software reset request
//   sync_rst    out  NUM_OUT  active-low resets (0 = in reset, 1 = released)
//   rst_done    out  1        1 when all outputs are released and FSM is DONE
// BEHAVIOUR
// - rst=1: asynchronously clear the synchroniser chain, the counters and
//   every output flop. sync_rst=0 and rst_done=0 immediately.
//   The FSM goes to SYNC. This holds in every state, including mid-SW pulse.
// - An rst pulse shorter than one clock still fully clears the chain.
// - Edge n = n-th rising clk edge after rst falls (setup met).
//   Chain output is 1 after edge NUM_STAGES.
// - FSM states and transitions:
//     SYNC: go to HOLD when the chain output is 1.
//     HOLD: count MIN_HOLD cycles, then go to REL.
//     REL:  release outputs 0..NUM_OUT-1 one per STAGGER cycles,
//           then go to DONE.
//     DONE: steady state. Go to SWR when sw_rst_req=1.
//     SWR:  hold all outputs in reset for SW_PULSE cycles, then go to REL.
// - Release timing after rst:
//     sync_rst[0] rises after edge NUM_STAGES+MIN_HOLD.
//     sync_rst[i] rises after edge NUM_STAGES+MIN_HOLD+i*STAGGER.
//     rst_done rises on the same edge as sync_rst[NUM_OUT-1].
//   With defaults: edges 6, 8, 10; rst_done at edge 10.
// - Software reset (sw_rst_req=1 sampled at edge k while in DONE):
//     After edge k, all sync_rst=0 and rst_done=0.
//     sync_rst[i] rises after edge k+SW_PULSE+i*STAGGER.
//     rst_done rises with the last output.
// - sw_rst_req in any state other than DONE is ignored, not queued.
//   A held-high request re-triggers only after DONE is reached again.
// - Outputs are released monotonically in index order. Once released, an
//   output stays 1 until rst or an accepted sw request. Never glitches.
// - Every output is driven directly by a flop with async clear; no
//   combinational logic drives the output ports.
// - NUM_OUT=1: there is no stagger. rst_done rises with sync_rst[0].
// - Counter widths use $clog2 of the largest of MIN_HOLD, STAGGER and
//   SW_PULSE, plus 1. Counters do not wrap in normal operation.
// TESTING
//   1. Defaults. rst=1 for 3 cycles, then drop ->
//      sync_rst=000 until edge 6; 001@6, 011@8, 111@10; rst_done=1@10.
//   2. Assert rst for 1ns mid-cycle while in DONE ->
//      sync_rst=000 and rst_done=0 immediately (async); the sequence of
//      test 1 replays from the rst fall.
//   3. sw_rst_req 1-cycle pulse at edge 20 in DONE ->
//      000 after edge 20; 001@28, 011@30, 111@32; rst_done=1@32.
//   4. sw_rst_req pulsed during HOLD and during REL ->
//      ignored; release edges are identical to test 1.
//   5. rst asserted during the SWR state (edge 24 of test 3) ->
//      immediate clear; after rst falls, release timing follows test 1
//      rather than SW timing.
//   6. NUM_STAGES=3, MIN_HOLD=1, NUM_OUT=1 ->
//      sync_rst[0] and rst_done rise together at edge 4. Check for no
//      X on the outputs and no output toggling between releases.

Source files
------------

// File: rtl/rst_seq_sync.sv
// rst_seq_sync: reset synchroniser and sequencer.
// Reset asserts asynchronously and releases synchronously. All outputs are
// then held for a minimum stretch before being released one by one, STAGGER
// cycles apart. A software request seen in DONE re-runs the hold and release.
module rst_seq_sync #(
    parameter int NUM_STAGES = 2,
    parameter int MIN_HOLD   = 4,
    parameter int NUM_OUT    = 3,
    parameter int STAGGER    = 2,
    parameter int SW_PULSE   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_rst_req,
    output logic [NUM_OUT-1:0] sync_rst,
    output logic               rst_done
);

    localparam int MAX_HS  = (MIN_HOLD > STAGGER) ? MIN_HOLD : STAGGER;
    localparam int MAX_CNT = (MAX_HS > SW_PULSE) ? MAX_HS : SW_PULSE;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam int IDX_W   = $clog2(NUM_OUT) + 1;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_HOLD = 3'd1,
        ST_REL  = 3'd2,
        ST_DONE = 3'd3,
        ST_SWR  = 3'd4
    } state_t;

    // The state register leaving SYNC acts as the last synchroniser stage,
    // so only NUM_STAGES-1 dedicated chain flops are needed. This lets the
    // FSM enter HOLD on exactly the edge the full chain would read 1.
    logic [NUM_STAGES-2:0] sync_chain_reg;
    logic                  chain_out;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [NUM_OUT-1:0] out_reg, out_next;
    logic               done_reg, done_next;
    logic [NUM_OUT-1:0] idx_mask;
    logic               cnt_zero;
    logic               last_idx;

    // Synchroniser chain: shifts in a constant 1, cleared asynchronously.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES - 1; gi++) begin : g_chain
            if (gi == 0) begin : g_first
                // First stage samples the released reset level.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_chain_reg[gi] <= 1'b0;
                    else     sync_chain_reg[gi] <= 1'b1;
                end
            end else begin : g_rest
                // Later stages shift the level along the chain.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_chain_reg[gi] <= 1'b0;
                    else     sync_chain_reg[gi] <= sync_chain_reg[gi-1];
                end
            end
        end

        // One-hot mask selecting the output currently due for release.
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_mask
            assign idx_mask[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign chain_out = sync_chain_reg[NUM_STAGES-2];
    assign cnt_zero  = (cnt_reg == '0);
    assign last_idx  = (idx_reg == IDX_W'(NUM_OUT - 1));

    // State, counters and output flops; outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_SYNC;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            out_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            out_reg   <= out_next;
            done_reg  <= done_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_SYNC: if (chain_out) state_next = ST_HOLD;
            ST_HOLD, ST_SWR, ST_REL: begin
                if (cnt_zero) state_next = last_idx ? ST_DONE : ST_REL;
            end
            ST_DONE: if (sw_rst_req) state_next = ST_SWR;
            default: state_next = ST_SYNC;
        endcase
    end

    // Counter, release index and output-flop next values.
    always_comb begin
        cnt_next  = cnt_reg;
        idx_next  = idx_reg;
        out_next  = out_reg;
        done_next = done_reg;
        case (state_reg)
            ST_SYNC: begin
                out_next  = '0;
                done_next = 1'b0;
                idx_next  = '0;
                if (chain_out) cnt_next = CNT_W'(MIN_HOLD - 1);
            end
            ST_HOLD, ST_SWR, ST_REL: begin
                if (cnt_zero) begin
                    // Release the indexed output; outputs only ever set bits.
                    out_next = out_reg | idx_mask;
                    if (last_idx) begin
                        done_next = 1'b1;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                        cnt_next = CNT_W'(STAGGER - 1);
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (sw_rst_req) begin
                    out_next  = '0;
                    done_next = 1'b0;
                    idx_next  = '0;
                    cnt_next  = CNT_W'(SW_PULSE - 1);
                end
            end
            default: begin
                out_next  = '0;
                done_next = 1'b0;
            end
        endcase
    end

    assign sync_rst = out_reg;
    assign rst_done = done_reg;

endmodule

// File: tb/tb_rst_seq_sync.sv
// Bench for rst_seq_sync: default instance checked each cycle against an
// edge-count model; a second instance covers the single-output case.
module tb_rst_seq_sync;

    localparam int NS  = 2;
    localparam int MH  = 4;
    localparam int NO  = 3;
    localparam int STG = 2;
    localparam int SWP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sw  = 1'b0;
    logic [NO-1:0] sync_rst;
    logic          rst_done;

    logic          rst2 = 1'b1;
    logic          sw2  = 1'b0;
    logic [0:0]    sync_rst2;
    logic          rst_done2;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: edges since rst fell, and the edge on which output 0 releases.
    int m_n    = 0;
    int m_base = NS + MH;

    always #5 clk = ~clk;

    rst_seq_sync #(.NUM_STAGES(NS), .MIN_HOLD(MH), .NUM_OUT(NO),
                   .STAGGER(STG), .SW_PULSE(SWP)) dut (
        .clk(clk), .rst(rst), .sw_rst_req(sw),
        .sync_rst(sync_rst), .rst_done(rst_done)
    );

    rst_seq_sync #(.NUM_STAGES(3), .MIN_HOLD(1), .NUM_OUT(1),
                   .STAGGER(2), .SW_PULSE(8)) dut1 (
        .clk(clk), .rst(rst2), .sw_rst_req(sw2),
        .sync_rst(sync_rst2), .rst_done(rst_done2)
    );

    // Reference model: output i is released once the edge count reaches
    // base + i*STAGGER; an accepted sw request moves base to k + SW_PULSE.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n    <= 0;
            m_base <= NS + MH;
        end else begin
            if (sw && (m_n >= m_base + (NO - 1) * STG))
                m_base <= m_n + 1 + SWP;
            m_n <= m_n + 1;
        end
    end

    function automatic logic [NO-1:0] exp_out();
        logic [NO-1:0] e;
        for (int i = 0; i < NO; i++) e[i] = !rst && (m_n >= m_base + i * STG);
        return e;
    endfunction

    function automatic logic exp_done();
        return !rst && (m_n >= m_base + (NO - 1) * STG);
    endfunction

    task automatic test_reset();
        logic [NO-1:0] want;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (sync_rst !== '0 || rst_done !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold sync_rst=%b rst_done=%b required 000/0", sync_rst, rst_done);
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            want = (e >= 10) ? 3'b111 : (e >= 8) ? 3'b011 : (e >= 6) ? 3'b001 : 3'b000;
            n_cmp++;
            if (sync_rst !== want || rst_done !== (e >= 10) || sync_rst !== exp_out()) begin
                n_bad++;
                $display("FAIL reset_release edge=%0d sync_rst=%b rst_done=%b required %b/%b",
                         e, sync_rst, rst_done, want, (e >= 10));
            end
        end
    endtask

    task automatic test_async_pulse();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (sync_rst !== '0 || rst_done !== 1'b0) begin
            n_bad++;
            $display("FAIL async_clear sync_rst=%b rst_done=%b required 000/0", sync_rst, rst_done);
        end
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            n_cmp++;
            if (sync_rst !== exp_out() || rst_done !== exp_done()) begin
                n_bad++;
                $display("FAIL async_replay edge=%0d sync_rst=%b rst_done=%b required %b/%b",
                         e, sync_rst, rst_done, exp_out(), exp_done());
            end
        end
    endtask

    task automatic test_sw_reset();
        repeat ($urandom_range(0, 5)) @(negedge clk);
        sw = 1'b1;
        @(negedge clk);
        sw = 1'b0;
        n_cmp++;
        if (sync_rst !== '0 || rst_done !== 1'b0) begin
            n_bad++;
            $display("FAIL sw_clear sync_rst=%b rst_done=%b required 000/0", sync_rst, rst_done);
        end
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            n_cmp++;
            if (sync_rst !== exp_out() || rst_done !== exp_done()) begin
                n_bad++;
                $display("FAIL sw_release cyc=%0d sync_rst=%b rst_done=%b required %b/%b",
                         c, sync_rst, rst_done, exp_out(), exp_done());
            end
        end
    endtask

    task automatic test_sw_ignored();
        int h, r;
        h = $urandom_range(3, 5);
        r = $urandom_range(7, 9);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            sw = (e == h || e == r);
            @(negedge clk);
            sw = 1'b0;
            n_cmp++;
            if (sync_rst !== exp_out() || rst_done !== exp_done() || rst_done !== (e >= 10)) begin
                n_bad++;
                $display("FAIL sw_ignored edge=%0d sync_rst=%b rst_done=%b required %b/%b",
                         e, sync_rst, rst_done, exp_out(), exp_done());
            end
        end
    endtask

    task automatic test_rst_in_swr();
        sw = 1'b1;
        @(negedge clk);
        sw = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (sync_rst !== '0 || rst_done !== 1'b0) begin
            n_bad++;
            $display("FAIL swr_rst_clear sync_rst=%b rst_done=%b required 000/0", sync_rst, rst_done);
        end
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            n_cmp++;
            if (sync_rst !== exp_out() || rst_done !== exp_done() || rst_done !== (e >= 10)) begin
                n_bad++;
                $display("FAIL swr_rst_replay edge=%0d sync_rst=%b rst_done=%b required %b/%b",
                         e, sync_rst, rst_done, exp_out(), exp_done());
            end
        end
    endtask

    task automatic test_back_to_back();
        sw = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_cmp++;
            if (sync_rst !== exp_out() || rst_done !== exp_done()) begin
                n_bad++;
                $display("FAIL sw_held cyc=%0d sync_rst=%b rst_done=%b required %b/%b",
                         c, sync_rst, rst_done, exp_out(), exp_done());
            end
        end
        for (int c = 0; c < 120; c++) begin
            sw = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            n_cmp++;
            if (sync_rst !== exp_out() || rst_done !== exp_done()) begin
                n_bad++;
                $display("FAIL random cyc=%0d sync_rst=%b rst_done=%b required %b/%b",
                         c, sync_rst, rst_done, exp_out(), exp_done());
            end
            if ($urandom_range(0, 24) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        sw = 1'b0;
    endtask

    task automatic test_single_out();
        @(negedge clk);
        n_cmp++;
        if (sync_rst2 !== 1'b0 || rst_done2 !== 1'b0) begin
            n_bad++;
            $display("FAIL single_reset sync_rst=%b rst_done=%b required 0/0", sync_rst2, rst_done2);
        end
        rst2 = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            n_cmp++;
            if (sync_rst2 !== 1'(e >= 4) || rst_done2 !== (e >= 4)) begin
                n_bad++;
                $display("FAIL single_release edge=%0d sync_rst=%b rst_done=%b required %b/%b",
                         e, sync_rst2, rst_done2, (e >= 4), (e >= 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_async_pulse();
        test_sw_reset();
        test_sw_ignored();
        test_rst_in_swr();
        test_back_to_back();
        test_single_out();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
